load_store_unit: RTL
====================

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32: width of data and address buses.
REQ-002 SHALL have parameter MEMORY_DEPTH, default 256: number of words in the attached data memory.
REQ-003 SHALL have parameter BASE_ADDR, default 32'h10010000: byte address of data memory word 0.
REQ-004 SHALL use one clock and an asynchronous, active-high reset, with ports as listed below.
REQ-005 SHALL have port clk, input, 1 bit: clock, all state updates on the rising edge.
REQ-006 SHALL have port reset, input, 1 bit: asynchronous active-high reset.
REQ-007 SHALL have port req_valid_i, input, 1 bit: the CPU presents an access.
REQ-008 SHALL have port req_ready_o, output, 1 bit: the unit accepts an access this cycle.
REQ-009 SHALL have port req_we_i, input, 1 bit: 1 selects store, 0 selects load.
REQ-010 SHALL have port req_size_i, input, 2 bits: 00 byte, 01 half, 10 word; 11 is illegal.
REQ-011 SHALL have port req_unsigned_i, input, 1 bit: zero-extend loads when 1, sign-extend when 0.
REQ-012 SHALL have port req_addr_i, input, DATA_WIDTH bits: byte address.
REQ-013 SHALL have port req_wdata_i, input, DATA_WIDTH bits: store data, right-aligned.
REQ-014 SHALL have port resp_valid_o, output, 1 bit: one-cycle completion pulse.
REQ-015 SHALL have port resp_err_o, output, 1 bit: fault flag, valid with resp_valid_o.
REQ-016 SHALL have port resp_rdata_o, output, DATA_WIDTH bits: extended load result.
REQ-017 SHALL have port Mem_Write_o, output, 1 bit: drives the data memory write enable.
REQ-018 SHALL have port Mem_Read_o, output, 1 bit: drives the data memory read enable.
REQ-019 SHALL have port Address_o, output, DATA_WIDTH bits: word-aligned byte address, {addr[31:2],2'b00}.
REQ-020 SHALL have port Write_Data_o, output, DATA_WIDTH bits: full word to write.
REQ-021 SHALL have port Read_Data_i, input, DATA_WIDTH bits: combinational read word from memory.

Function
REQ-022 SHALL implement states IDLE, READ, WRITE, RESP.
REQ-023 SHALL assert req_ready_o only in IDLE; acceptance is req_valid_i & req_ready_o at a rising edge, latching all req_* fields.
REQ-024 SHALL treat as fault: size 11, half with addr[0]=1, word with addr[1:0]!=0, or addr outside [BASE_ADDR, BASE_ADDR+4*MEMORY_DEPTH-1].
REQ-025 SHALL move a faulting access IDLE->RESP with resp_err_o=1, resp_rdata_o=0, and no memory enable asserted.
REQ-026 SHALL move a load IDLE->READ->RESP; in READ, Mem_Read_o=1 and Read_Data_i is captured at the exiting edge.
REQ-027 SHALL move a word store IDLE->WRITE->RESP; in WRITE, Mem_Write_o=1 for exactly one cycle with Write_Data_o=wdata.
REQ-028 SHALL move a byte or half store IDLE->READ->WRITE->RESP, merging the shifted wdata lanes into the captured word (read-modify-write).
REQ-029 SHALL select lanes little-endian: byte lane addr[1:0], half lane addr[1].
REQ-030 SHALL extend load data from the selected lane per req_unsigned_i; word loads pass through unchanged.
REQ-031 SHALL assert resp_valid_o for exactly one cycle in RESP and then return to IDLE; there is no response backpressure.
REQ-032 SHALL give a latency from accept edge to resp_valid_o high of 2 cycles for loads and word stores, 3 cycles for sub-word stores, and 1 cycle for faults.
REQ-033 SHALL hold Mem_Read_o, Mem_Write_o, Address_o and Write_Data_o at 0 outside READ and WRITE.
REQ-034 SHALL ignore req_* inputs while not in IDLE.
REQ-035 SHALL hold resp_rdata_o and resp_err_o at 0 except in RESP; for stores, resp_rdata_o is 0.

Reset
REQ-036 SHALL, while reset=1, immediately force state IDLE and all outputs to 0 except req_ready_o, which is 0 during reset and 1 in the first cycle after release.
REQ-037 SHALL abandon any access on reset mid-operation, with no write pulse emitted after the assertion and no response produced.

Verification
REQ-038 SHALL pass: word store 0xDEADBEEF at 0x10010004, then word load there -> Mem_Write_o one cycle at Address_o 0x10010004; load returns 0xDEADBEEF 2 cycles after accept.
REQ-039 SHALL pass: byte store 0xAB at 0x10010005 onto word 0x11223344 -> memory write 0x1122AB44; signed byte load at 0x10010005 -> 0xFFFFFFAB; unsigned -> 0x000000AB.
REQ-040 SHALL pass: half load at 0x10010003 -> resp_err_o=1 one cycle after accept; Mem_Read_o and Mem_Write_o never asserted.
REQ-041 SHALL pass: word load at 0x10010400 (past depth 256) and at 0x1000FFFC -> resp_err_o=1 for each.
REQ-042 SHALL pass: reset asserted in the READ cycle of a half store -> outputs 0 at once, no Mem_Write_o pulse, target word unchanged, next request served normally.
REQ-043 SHALL pass: req_valid_i held high continuously -> accepts spaced by RESP plus 1 cycle; fields changed mid-access have no effect.

Source files
------------

// File: rtl/load_store_unit_if.sv
// CPU request/response handshake plus data-memory port of the load/store unit.
// The slave modport is the unit; the master modport is the CPU/memory environment.
interface load_store_unit_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  req_valid_i;
    logic                  req_ready_o;
    logic                  req_we_i;
    logic [1:0]            req_size_i;
    logic                  req_unsigned_i;
    logic [DATA_WIDTH-1:0] req_addr_i;
    logic [DATA_WIDTH-1:0] req_wdata_i;
    logic                  resp_valid_o;
    logic                  resp_err_o;
    logic [DATA_WIDTH-1:0] resp_rdata_o;
    logic                  Mem_Write_o;
    logic                  Mem_Read_o;
    logic [DATA_WIDTH-1:0] Address_o;
    logic [DATA_WIDTH-1:0] Write_Data_o;
    logic [DATA_WIDTH-1:0] Read_Data_i;

    modport slave (
        input  req_valid_i, req_we_i, req_size_i, req_unsigned_i, req_addr_i, req_wdata_i,
               Read_Data_i,
        output req_ready_o, resp_valid_o, resp_err_o, resp_rdata_o,
               Mem_Write_o, Mem_Read_o, Address_o, Write_Data_o
    );

    modport master (
        output req_valid_i, req_we_i, req_size_i, req_unsigned_i, req_addr_i, req_wdata_i,
               Read_Data_i,
        input  req_ready_o, resp_valid_o, resp_err_o, resp_rdata_o,
               Mem_Write_o, Mem_Read_o, Address_o, Write_Data_o
    );
endinterface

// File: rtl/load_store_unit.sv
// Single-outstanding load/store unit: sub-word stores use read-modify-write,
// loads are lane-selected little-endian and sign/zero extended.
module load_store_unit #(
    parameter int                    DATA_WIDTH   = 32,
    parameter int                    MEMORY_DEPTH = 256,
    parameter logic [DATA_WIDTH-1:0] BASE_ADDR    = DATA_WIDTH'(32'h10010000)
) (
    input  logic              clk,
    input  logic              reset,
    load_store_unit_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

    localparam logic [1:0]            SZ_BYTE = 2'b00;
    localparam logic [1:0]            SZ_HALF = 2'b01;
    localparam logic [1:0]            SZ_WORD = 2'b10;
    localparam logic [DATA_WIDTH:0]   SPAN    = (DATA_WIDTH+1)'(4 * MEMORY_DEPTH);

    state_t                state_q, state_d;
    logic                  we_q, uns_q, err_q;
    logic [1:0]            size_q;
    logic [DATA_WIDTH-1:0] addr_q, wdata_q, word_q;

    logic                  accept, fault, in_range;
    logic [DATA_WIDTH-1:0] offset, aligned, lane_mask, merged, store_word, lane, load_data;
    logic [4:0]            sh;

    assign accept   = bus.req_valid_i & bus.req_ready_o;
    assign offset   = bus.req_addr_i - BASE_ADDR;
    assign in_range = (bus.req_addr_i >= BASE_ADDR) && ({1'b0, offset} < SPAN);

    always_comb begin
        fault = 1'b0;
        case (bus.req_size_i)
            SZ_BYTE: fault = 1'b0;
            SZ_HALF: fault = bus.req_addr_i[0];
            SZ_WORD: fault = |bus.req_addr_i[1:0];
            default: fault = 1'b1;
        endcase
        if (!in_range) fault = 1'b1;
    end

    // Lane shift in bits: half lanes follow addr[1], byte lanes addr[1:0].
    assign sh         = (size_q == SZ_HALF) ? {addr_q[1], 4'b0000} : {addr_q[1:0], 3'b000};
    assign aligned    = {addr_q[DATA_WIDTH-1:2], 2'b00};
    assign lane_mask  = (size_q == SZ_BYTE) ? DATA_WIDTH'(8'hFF) : DATA_WIDTH'(16'hFFFF);
    assign merged     = (word_q & ~(lane_mask << sh)) | ((wdata_q & lane_mask) << sh);
    assign store_word = (size_q == SZ_WORD) ? wdata_q : merged;
    assign lane       = word_q >> sh;

    always_comb begin
        load_data = word_q;
        if (size_q == SZ_BYTE)
            load_data = {{(DATA_WIDTH-8){~uns_q & lane[7]}}, lane[7:0]};
        else if (size_q == SZ_HALF)
            load_data = {{(DATA_WIDTH-16){~uns_q & lane[15]}}, lane[15:0]};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            we_q    <= 1'b0;
            uns_q   <= 1'b0;
            err_q   <= 1'b0;
            size_q  <= 2'b00;
            addr_q  <= '0;
            wdata_q <= '0;
            word_q  <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                we_q    <= bus.req_we_i;
                uns_q   <= bus.req_unsigned_i;
                size_q  <= bus.req_size_i;
                addr_q  <= bus.req_addr_i;
                wdata_q <= bus.req_wdata_i;
                err_q   <= fault;
            end
            if (state_q == READ) word_q <= bus.Read_Data_i;
        end
    end

    always_comb begin
        state_d          = state_q;
        bus.req_ready_o  = (state_q == IDLE) & ~reset;
        bus.resp_valid_o = 1'b0;
        bus.resp_err_o   = 1'b0;
        bus.resp_rdata_o = '0;
        bus.Mem_Write_o  = 1'b0;
        bus.Mem_Read_o   = 1'b0;
        bus.Address_o    = '0;
        bus.Write_Data_o = '0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (fault)
                        state_d = RESP;
                    else if (bus.req_we_i && bus.req_size_i == SZ_WORD)
                        state_d = WRITE;
                    else
                        state_d = READ;
                end
            end
            READ: begin
                bus.Mem_Read_o = 1'b1;
                bus.Address_o  = aligned;
                state_d        = we_q ? WRITE : RESP;
            end
            WRITE: begin
                bus.Mem_Write_o  = 1'b1;
                bus.Address_o    = aligned;
                bus.Write_Data_o = store_word;
                state_d          = RESP;
            end
            RESP: begin
                bus.resp_valid_o = 1'b1;
                bus.resp_err_o   = err_q;
                bus.resp_rdata_o = (err_q || we_q) ? '0 : load_data;
                state_d          = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end
endmodule
